// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the register-bank arbiter.
// Holds the FSM state enum, default sizes and the index-width helper.
package reg_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int N_REQ_DEF    = 4;
  localparam int WIDTH_DEF    = 8;
  localparam int MAX_HOLD_DEF = 4;

  // Bits needed to index n items; never less than 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit after owner.
// In: req, owner. Out: one-hot next, valid (any req set).
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]            req,
  input  logic [idx_w(N_REQ)-1:0]     owner,
  output logic [N_REQ-1:0]            next,
  output logic                        valid
);

  localparam int IW = idx_w(N_REQ);

  logic [IW-1:0] k;

  // Scan owner+1 .. owner+N_REQ so the owner itself is checked last.
  always_comb begin
    next  = '0;
    valid = 1'b0;
    k     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = IW'((int'(owner) + i) % N_REQ);
      if (!valid && req[k]) begin
        next[k] = 1'b1;
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter writing one shared register from N requesters.
// Ports: clk, rst_n, req, D in; gnt, owner, busy, Q, nQ out.
module reg_bank_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*WIDTH-1:0]    D,
  output logic [N_REQ-1:0]          gnt,
  output logic [idx_w(N_REQ)-1:0]   owner,
  output logic                      busy,
  output logic [WIDTH-1:0]          Q,
  output logic [WIDTH-1:0]          nQ
);

  localparam int IW = idx_w(N_REQ);
  localparam int HW = idx_w(MAX_HOLD + 1);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [WIDTH-1:0]  q_q, q_d;

  logic [N_REQ-1:0]  pick;
  logic              pick_vld;
  logic [IW-1:0]     pick_idx;
  logic              own_req;
  logic              others;
  logic [WIDTH-1:0]  d_sel;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (req),
    .owner (owner_q),
    .next  (pick),
    .valid (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) pick_idx = IW'(i);
    end
  end

  assign own_req = req[owner_q];
  assign others  = |(req & ~gnt_q);
  assign d_sel   = D[int'(owner_q)*WIDTH +: WIDTH];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    q_d     = q_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          gnt_d   = pick;
          owner_d = pick_idx;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!own_req) begin
          // Owner released: pick excludes it since its req is low.
          hold_d = '0;
          if (others) begin
            gnt_d   = pick;
            owner_d = pick_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else begin
          q_d = d_sel;
          if (hold_q == HW'(MAX_HOLD - 1)) begin
            // This load reaches the hold limit.
            hold_d = '0;
            if (others) begin
              gnt_d   = pick;
              owner_d = pick_idx;
            end
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= IW'(N_REQ - 1);
      hold_q  <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      q_q     <= q_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = (state_q == GRANT);
  assign Q     = q_q;
  assign nQ    = ~q_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter (N_REQ=4, WIDTH=8, MAX_HOLD=4).
// Inputs change and outputs are sampled on the falling edge.
module tb_reg_bank_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*W-1:0] d;
  logic [N-1:0]  gnt;
  logic [1:0]    owner;
  logic          busy;
  logic [W-1:0]  q;
  logic [W-1:0]  nq;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  reg_bank_arbiter #(
    .N_REQ    (N),
    .WIDTH    (W),
    .MAX_HOLD (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .D     (d),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .Q     (q),
    .nQ    (nq)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_d(input int k, input logic [W-1:0] v);
    d[k*W +: W] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    d     = '0;
    @(negedge clk);
    do_reset();

    chk("rst_gnt",   32'(gnt),   32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_q",     32'(q),     32'h00);
    chk("rst_nq",    32'(nq),    32'hFF);
    chk("rst_owner", 32'(owner), 32'h3);

    // Single request.
    req = 4'b0001;
    set_d(0, 8'hA5);
    step();
    chk("single_gnt",   32'(gnt),   32'h1);
    chk("single_busy",  32'(busy),  32'h1);
    chk("single_owner", 32'(owner), 32'h0);
    chk("single_q0",    32'(q),     32'h00);
    step();
    chk("single_q",  32'(q),  32'hA5);
    chk("single_nq", 32'(nq), 32'h5A);
    req = '0;
    set_d(0, 8'h11);
    step();
    chk("single_rel_gnt",  32'(gnt),  32'h0);
    chk("single_rel_busy", 32'(busy), 32'h0);
    chk("single_rel_q",    32'(q),    32'hA5);

    // Fairness: all four requesting, order 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    step();
    chk("fair_first", 32'(gnt), 32'h1);
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        int k;
        k = g % N;
        for (int j = 0; j < N; j++)
          set_d(j, 8'(j*64 + g*8 + c));
        step();
        chk($sformatf("fair_q_g%0d_c%0d", g, c),
            32'(q), 32'(k*64 + g*8 + c));
        if (c < 3)
          chk($sformatf("fair_gnt_g%0d_c%0d", g, c),
              32'(gnt), 32'(1 << k));
        else
          chk($sformatf("fair_hand_g%0d", g),
              32'(gnt), 32'(1 << ((k + 1) % N)));
      end
    end

    // Early release with another request pending.
    do_reset();
    req = 4'b0100;
    step();
    chk("rel_gnt2", 32'(gnt), 32'h4);
    set_d(2, 8'h3C);
    step();
    chk("rel_q3c", 32'(q), 32'h3C);
    req = 4'b1100;
    set_d(2, 8'h3D);
    step();
    chk("rel_nopreempt", 32'(gnt), 32'h4);
    chk("rel_q3d",       32'(q),   32'h3D);
    req = 4'b1000;
    set_d(2, 8'h77);
    set_d(3, 8'h88);
    step();
    chk("rel_hand_gnt",   32'(gnt),   32'h8);
    chk("rel_hand_owner", 32'(owner), 32'h3);
    chk("rel_noload",     32'(q),     32'h3D);
    chk("rel_busy",       32'(busy),  32'h1);
    step();
    chk("rel_q88", 32'(q), 32'h88);

    // Sole requester for 10 loads, counter wraps.
    do_reset();
    req = 4'b0010;
    step();
    chk("sole_gnt0", 32'(gnt), 32'h2);
    for (int i = 0; i < 10; i++) begin
      set_d(1, 8'(8'h40 + i));
      step();
      chk($sformatf("sole_gnt_%0d", i), 32'(gnt), 32'h2);
      chk($sformatf("sole_q_%0d", i),   32'(q),   32'(8'h40 + i));
    end

    // Release on the same edge the hold limit is reached.
    set_d(1, 8'h5E);
    step();
    chk("simul_q",   32'(q),   32'h5E);
    chk("simul_gnt", 32'(gnt), 32'h2);
    req = '0;
    set_d(1, 8'hEE);
    step();
    chk("simul_idle_gnt",  32'(gnt),  32'h0);
    chk("simul_idle_busy", 32'(busy), 32'h0);
    chk("simul_noload",    32'(q),    32'h5E);

    // Reset in the middle of a grant.
    req = 4'b0001;
    set_d(0, 8'h3C);
    step();
    step();
    chk("mid_q3c",  32'(q),    32'h3C);
    chk("mid_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    req   = 4'b1111;
    step();
    chk("mid_rst_gnt",   32'(gnt),   32'h0);
    chk("mid_rst_q",     32'(q),     32'h00);
    chk("mid_rst_nq",    32'(nq),    32'hFF);
    chk("mid_rst_owner", 32'(owner), 32'h3);
    chk("mid_rst_busy",  32'(busy),  32'h0);
    rst_n = 1'b1;
    step();
    chk("mid_tie_gnt",   32'(gnt),   32'h1);
    chk("mid_tie_owner", 32'(owner), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
